// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter between NREQ byte
//   sources. In IDLE it picks the first requester at or after the rotating
//   pointer, captures that source's byte and fires a one-cycle tx_start. It then
//   follows tx_busy through the frame before it accepts the next request.
//
// Ports
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   req          level request per source (sampled only in IDLE)
//   req_data     byte of source i at [i*DATA_W +: DATA_W]
//   grant        one-hot, 1-cycle pulse: the winner's byte was captured
//   tx_start     1-cycle pulse to the UART core
//   tx_data      captured byte, stable from tx_start until the return to IDLE
//   tx_busy      UART core busy flag
//   arb_idle     high while the FSM is in IDLE (decoded, not registered)
//   timeout_err  1-cycle pulse: tx_busy never rose after tx_start

module uart_tx_arbiter #(
  parameter int NREQ        = 3,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        grant,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic                   arb_idle,
  output logic                   timeout_err
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state, state_d;
  logic [PTR_W-1:0]  ptr, ptr_d;
  logic [7:0]        cnt, cnt_d;
  logic [NREQ-1:0]   grant_d;
  logic              tx_start_d, timeout_d;
  logic [DATA_W-1:0] tx_data_d;

  logic              win_vld;
  logic [PTR_W-1:0]  win, win_nxt;
  logic              timeout_hit;

  // Scan from the farthest candidate back toward ptr so the closest set
  // request (in wrap-around order) is the last one written and wins.
  always_comb begin
    logic [PTR_W:0] idx;
    idx     = '0;
    win_vld = 1'b0;
    win     = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NREQ)) idx = idx - (PTR_W+1)'(NREQ);
      if (req[idx[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win     = idx[PTR_W-1:0];
      end
    end
  end

  assign win_nxt     = (win == PTR_W'(NREQ-1)) ? '0 : win + PTR_W'(1);
  assign timeout_hit = (state == WAIT_BUSY) && (cnt == 8'(ACK_TIMEOUT-1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic. The timeout cycle always returns to IDLE: the error has
  // already been reported, and a late busy just holds IDLE off new grants.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (win_vld && !tx_busy) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (timeout_hit)         state_d = IDLE;
                 else if (tx_busy)        state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy)            state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    ptr_d      = ptr;
    cnt_d      = cnt;
    case (state)
      IDLE: if (win_vld && !tx_busy) begin
        grant_d[win] = 1'b1;
        tx_start_d   = 1'b1;
        tx_data_d    = req_data[win*DATA_W +: DATA_W];
        ptr_d        = win_nxt;
      end
      START:     cnt_d = '0;
      WAIT_BUSY: if (!timeout_hit && !tx_busy) cnt_d = cnt + 8'd1;
      default: ;
    endcase
    // Registered pulse lands in the WAIT_BUSY cycle where cnt hits the limit.
    timeout_d = (state_d == WAIT_BUSY) && (cnt_d == 8'(ACK_TIMEOUT-1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      ptr         <= ptr_d;
      cnt         <= cnt_d;
      grant       <= grant_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      timeout_err <= timeout_d;
    end
  end

  assign arb_idle = (state == IDLE);

endmodule
